// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program counter with sequential, relative-branch, absolute-jump
// and return modes, backed by a small circular return-address stack (RAS).
//
// Parameters
//   ADDR_W    program-address width
//   IMM_W     immediate width (>= ADDR_W); only the low ADDR_W bits are used
//   RESET_VEC o_addr value after reset
//   STEP      sequential increment
//   RAS_DEPTH return-address-stack entries (power of two, >= 2)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   stall       1 = hold every piece of state this cycle
//   sel         next-address mode: 00 SEQ, 01 BRANCH, 10 JUMP, 11 RET
//   call        with sel=10, push the return address (o_addr + STEP)
//   imme        branch offset (BRANCH) or jump target (JUMP)
//   o_addr      registered current program address
//   o_ras_empty RAS holds no entries
//   o_ras_full  RAS holds RAS_DEPTH entries
//   o_err       sticky errors: bit0 RAS overflow, bit1 RAS underflow
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int                 ADDR_W    = 16,
    parameter int                 IMM_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter int                 STEP      = 1,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [1:0]        sel,
    input  logic              call,
    input  logic [IMM_W-1:0]  imme,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_ras_empty,
    output logic              o_ras_full,
    output logic [1:0]        o_err
);

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_RET    = 2'b11
    } sel_e;

    localparam int              PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] imm_a;
    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q;     // index of the most recently pushed entry
    logic [PTR_W:0]    cnt_q;     // valid entries, 0..RAS_DEPTH
    logic [1:0]        err_q;

    logic push, pop, overflow, underflow, ras_empty, ras_full;
    sel_e mode;

    // Upper immediate bits are deliberately discarded.
    logic unused_imme;
    assign unused_imme = ^imme;

    assign mode      = sel_e'(sel);
    assign seq       = addr_q + ADDR_W'(STEP);
    assign imm_a     = imme[ADDR_W-1:0];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL_CNT);

    assign push      = !stall && (mode == SEL_JUMP) && call;
    assign pop       = !stall && (mode == SEL_RET) && !ras_empty;
    assign overflow  = push && ras_full;
    assign underflow = !stall && (mode == SEL_RET) && ras_empty;

    // NOTE: addr_d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        addr_d = addr_q;
        if (!stall) begin
            unique case (mode)
                SEL_SEQ:    addr_d = seq;
                SEL_BRANCH: addr_d = seq + imm_a;
                SEL_JUMP:   addr_d = imm_a;
                SEL_RET:    addr_d = ras_empty ? seq : ras[top_q];
                default:    addr_d = addr_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= RESET_VEC;
            top_q  <= '1;      // first push lands in slot 0
            cnt_q  <= '0;
            err_q  <= '0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_q | {underflow, overflow};
            if (push) begin
                // When full, top+1 is the oldest slot, so the push
                // overwrites it and the count stays saturated.
                top_q <= top_q + PTR_W'(1);
                if (!ras_full) cnt_q <= cnt_q + (PTR_W + 1)'(1);
            end else if (pop) begin
                top_q <= top_q - PTR_W'(1);
                cnt_q <= cnt_q - (PTR_W + 1)'(1);
            end
        end
    end

    // NOTE: the stack storage has no reset; entries are only readable while
    // cnt_q says they are valid, and reset zeroes cnt_q, so stale contents
    // can never reach o_addr.
    always_ff @(posedge clk) begin
        if (push) ras[top_q + PTR_W'(1)] <= seq;
    end

    assign o_addr      = addr_q;
    assign o_ras_empty = ras_empty;
    assign o_ras_full  = ras_full;
    assign o_err       = err_q;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, program-address width.
REQ-002 SHALL have parameter IMM_W, default 32, immediate-operand width (IMM_W >= ADDR_W).
REQ-003 SHALL have parameter RESET_VEC, default 0, o_addr value after reset.
REQ-004 SHALL have parameter STEP, default 1, sequential increment.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >= 2).
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port stall  input  1  high = hold all state this cycle.
REQ-009 SHALL have port sel  input  2  next-address mode: 00 SEQ, 01 BRANCH (relative), 10 JUMP (absolute), 11 RET.
REQ-010 SHALL have port call  input  1  with sel=10 pushes the return address onto the RAS; ignored in other modes.
REQ-011 SHALL have port imme  input  IMM_W  offset (BRANCH) or target (JUMP).
REQ-012 SHALL have port o_addr  output  ADDR_W  registered current program address.
REQ-013 SHALL have port o_ras_empty  output  1  RAS holds zero entries.
REQ-014 SHALL have port o_ras_full  output  1  RAS holds RAS_DEPTH entries.
REQ-015 SHALL have port o_err  output  2  sticky errors: bit0 overflow, bit1 underflow.

Function
REQ-016 SHALL let seq = o_addr + STEP, all address arithmetic modulo 2^ADDR_W (wrap, no saturation).
REQ-017 SHALL, stall=0, sel=00: o_addr <= seq next edge (latency one cycle).
REQ-018 SHALL, stall=0, sel=01: o_addr <= seq + imme[ADDR_W-1:0]; upper imme bits ignored (two's-complement offset via wrap).
REQ-019 SHALL, stall=0, sel=10: o_addr <= imme[ADDR_W-1:0]; upper bits ignored.
REQ-020 SHALL, stall=0, sel=10, call=1: push seq; if RAS full, overwrite oldest entry (circular), count stays RAS_DEPTH, set o_err[0].
REQ-021 SHALL, stall=0, sel=11, RAS non-empty: o_addr <= top entry, pop one.
REQ-022 SHALL, stall=0, sel=11, RAS empty: o_addr <= seq, no pop, set o_err[1].
REQ-023 SHALL, stall=1: hold o_addr, RAS contents, count, o_err regardless of sel/call/imme.
REQ-024 SHALL keep RAS as circular buffer with ADDR_W-bit entries, top pointer and count 0..RAS_DEPTH; o_ras_empty/o_ras_full combinational from count.
REQ-025 SHALL clear o_err only by reset; bits never self-clear.
REQ-026 SHALL treat call=1 with sel != 10 as no push, no error.
REQ-027 SHALL produce no X on outputs when inputs are known; imme don't-care in SEQ/RET.

Reset
REQ-028 SHALL, rst_n=0, immediately (no clock) force o_addr=RESET_VEC, RAS count=0, o_err=00; o_ras_empty=1, o_ras_full=0.
REQ-029 SHALL hold reset state while rst_n=0 and resume at first rising clk edge after deassertion with SEQ/other mode evaluated from RESET_VEC.
REQ-030 SHALL, when reset asserted mid-operation (e.g. during stall or with RAS full), discard all RAS entries; no pre-reset state observable afterwards.

Verification (defaults ADDR_W=16, STEP=1, RESET_VEC=0, RAS_DEPTH=4)
REQ-031 SHALL cover: reset then 3 edges sel=00 -> o_addr 0,1,2,3; stall=1 for 2 edges -> o_addr stays 3.
REQ-032 SHALL cover: o_addr=10, sel=01, imme=32'hFFFF_FFFB (-5) -> o_addr=6; o_addr=16'hFFFF, sel=00 -> o_addr=0.
REQ-033 SHALL cover: o_addr=5, sel=10, call=1, imme=32'h0001_0123 -> o_addr=16'h0123, RAS top=6; then sel=11 -> o_addr=6, o_ras_empty=1.
REQ-034 SHALL cover: 5 consecutive calls from addresses 0x10,0x20,0x30,0x40,0x50 -> o_ras_full=1, o_err=01; 4 RETs return 0x51,0x41,0x31,0x21; 5th RET -> seq, o_err=11.
REQ-035 SHALL cover: rst_n pulsed low between edges with RAS full -> o_addr=0, o_ras_empty=1, o_err=00 before next clk edge.
REQ-036 SHALL cover: stall=1 with sel=10, call=1 -> no push, o_addr unchanged, o_err unchanged.
